// File: rtl/collision_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : collision_scan_ctrl
//  Description : Per-frame multi-point hitbox scanner for two ships sharing a
//                dual-port collision map. Port A serves ship 1, port B ship 2.
//                Optional macro COLLISION_SCAN_8PT_EN selects the 8-point
//                perimeter probe list; without it only the 4 corners are probed.
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_scan_ctrl #(
  parameter int SHIP_W = 32,   // hitbox width in screen pixels, even
  parameter int SHIP_H = 48,   // hitbox height in screen pixels, even
  parameter int MAP_W  = 320   // map row stride in half-resolution cells
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  x_pos1,
  input  logic [9:0]  y_pos1,
  input  logic [9:0]  x_pos2,
  input  logic [9:0]  y_pos2,
  output logic [16:0] addr_a,
  output logic [16:0] addr_b,
  input  logic        q_a,
  input  logic        q_b,
  output logic        collision1,
  output logic        collision2,
  output logic        busy,
  output logic        done
);

`ifdef COLLISION_SCAN_8PT_EN
  localparam int N = 8;
  localparam logic [10:0] W_HALF = 11'(SHIP_W / 2);
  localparam logic [10:0] H_HALF = 11'(SHIP_H / 2);
`else
  localparam int N = 4;
`endif
  localparam logic [2:0]  LAST   = 3'(N - 1);
  localparam logic [10:0] W_FULL = 11'(SHIP_W);
  localparam logic [10:0] H_FULL = 11'(SHIP_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  p;          // index of the probe currently on the address ports
  logic [9:0]  x1_l, y1_l, x2_l, y2_l;
  logic        hit1, hit2;
  logic        oob_a, oob_b;      // registered alongside addr_a / addr_b
  logic        oob_a_d, oob_b_d;  // aligned with q_a / q_b
  logic        live_d;            // q_a / q_b carry data for a real probe

  logic [2:0]  idx;
  logic [9:0]  sx1, sy1, sx2, sy2;
  logic [21:0] offs;
  logic [17:0] res_a, res_b;
  logic        hit1_nxt, hit2_nxt;

  // Probe offset table, packed as {dx, dy}
  function automatic logic [21:0] probe_offset(input logic [2:0] i);
    logic [21:0] o;
`ifdef COLLISION_SCAN_8PT_EN
    case (i)
      3'd0:    o = {11'd0,  11'd0};
      3'd1:    o = {W_HALF, 11'd0};
      3'd2:    o = {W_FULL, 11'd0};
      3'd3:    o = {11'd0,  H_HALF};
      3'd4:    o = {W_FULL, H_HALF};
      3'd5:    o = {11'd0,  H_FULL};
      3'd6:    o = {W_HALF, H_FULL};
      default: o = {W_FULL, H_FULL};
    endcase
`else
    case (i)
      3'd0:    o = {11'd0,  11'd0};
      3'd1:    o = {W_FULL, 11'd0};
      3'd2:    o = {11'd0,  H_FULL};
      default: o = {W_FULL, H_FULL};
    endcase
`endif
    return o;
  endfunction

  // Map address for one probe, packed as {oob, addr}; off-screen forces addr 0
  function automatic logic [17:0] probe_addr(input logic [9:0] x, input logic [9:0] y,
                                             input logic [10:0] dx, input logic [10:0] dy);
    logic [10:0] px, py;
    logic [16:0] lin;
    logic        oob;
    px  = {1'b0, x} + dx;
    py  = {1'b0, y} + dy;
    oob = (px > 11'd639) || (py > 11'd479);
    lin = 17'(px >> 1) + 17'(py >> 1) * 17'(MAP_W);
    return oob ? {1'b1, 17'd0} : {1'b0, lin};
  endfunction

  // Next probe: probe 0 from live inputs when starting, else p+1 from latched positions
  always_comb begin
    idx   = (state == IDLE) ? 3'd0 : p + 3'd1;
    sx1   = (state == IDLE) ? x_pos1 : x1_l;
    sy1   = (state == IDLE) ? y_pos1 : y1_l;
    sx2   = (state == IDLE) ? x_pos2 : x2_l;
    sy2   = (state == IDLE) ? y_pos2 : y2_l;
    offs  = probe_offset(idx);
    res_a = probe_addr(sx1, sy1, offs[21:11], offs[10:0]);
    res_b = probe_addr(sx2, sy2, offs[21:11], offs[10:0]);
    hit1_nxt = hit1 | (live_d & (oob_a_d | ~q_a));
    hit2_nxt = hit2 | (live_d & (oob_b_d | ~q_b));
  end

  // Scan sequencer with registered addresses, hit accumulation and results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      p          <= 3'd0;
      x1_l       <= 10'd0;
      y1_l       <= 10'd0;
      x2_l       <= 10'd0;
      y2_l       <= 10'd0;
      addr_a     <= 17'd0;
      addr_b     <= 17'd0;
      oob_a      <= 1'b0;
      oob_b      <= 1'b0;
      oob_a_d    <= 1'b0;
      oob_b_d    <= 1'b0;
      live_d     <= 1'b0;
      hit1       <= 1'b0;
      hit2       <= 1'b0;
      collision1 <= 1'b0;
      collision2 <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done    <= 1'b0;
      oob_a_d <= oob_a;
      oob_b_d <= oob_b;
      live_d  <= (state == SCAN);
      hit1    <= hit1_nxt;
      hit2    <= hit2_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            x1_l   <= x_pos1;
            y1_l   <= y_pos1;
            x2_l   <= x_pos2;
            y2_l   <= y_pos2;
            hit1   <= 1'b0;
            hit2   <= 1'b0;
            p      <= 3'd0;
            addr_a <= res_a[16:0];
            addr_b <= res_b[16:0];
            oob_a  <= res_a[17];
            oob_b  <= res_b[17];
            busy   <= 1'b1;
            state  <= SCAN;
          end else begin
            addr_a <= 17'd0;
            addr_b <= 17'd0;
            oob_a  <= 1'b0;
            oob_b  <= 1'b0;
          end
        end
        SCAN: begin
          if (p == LAST) begin
            addr_a <= 17'd0;
            addr_b <= 17'd0;
            oob_a  <= 1'b0;
            oob_b  <= 1'b0;
            state  <= DRAIN;
          end else begin
            p      <= p + 3'd1;
            addr_a <= res_a[16:0];
            addr_b <= res_b[16:0];
            oob_a  <= res_a[17];
            oob_b  <= res_b[17];
          end
        end
        DRAIN: begin
          // Last probe's data is on q now; fold it in as results are published
          collision1 <= hit1_nxt;
          collision2 <= hit2_nxt;
          done       <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_collision_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_scan_ctrl
//  Description : Directed self-checking bench for collision_scan_ctrl with a
//                behavioural synchronous-read collision map. Adapts to the
//                COLLISION_SCAN_8PT_EN build option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_scan_ctrl;

`ifdef COLLISION_SCAN_8PT_EN
  localparam int N = 8;
`else
  localparam int N = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  x_pos1, y_pos1, x_pos2, y_pos2;
  logic [16:0] addr_a, addr_b;
  logic        q_a = 1'b1;
  logic        q_b = 1'b1;
  logic        collision1, collision2, busy, done;

  logic        mem [0:131071];
  logic [16:0] exp_a [8];
  logic [16:0] exp_b [8];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Synchronous-read map model: data one clock after the address
  always @(posedge clk) begin
    q_a <= mem[addr_a];
    q_b <= mem[addr_b];
  end

  collision_scan_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .x_pos1(x_pos1), .y_pos1(y_pos1), .x_pos2(x_pos2), .y_pos2(y_pos2),
    .addr_a(addr_a), .addr_b(addr_b), .q_a(q_a), .q_b(q_b),
    .collision1(collision1), .collision2(collision2), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ships(input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] c, input logic [9:0] d);
    x_pos1 = a; y_pos1 = b; x_pos2 = c; y_pos2 = d;
  endtask

  // One scan from IDLE; positions are scrambled after cycle 0 to prove latching
  task automatic run_scan(input string name, input int restart_cyc, input logic chk_addr,
                          input logic exp_c1, input logic exp_c2);
    logic [9:0] sv [4];
    sv = '{x_pos1, y_pos1, x_pos2, y_pos2};
    start = 1'b1;
    for (int c = 1; c <= N + 3; c++) begin
      tick();
      start = (c == restart_cyc);
      if (c == 1) set_ships(10'd7, 10'd9, 10'd11, 10'd13);
      if (chk_addr && c <= N) begin
        checks++;
        if (addr_a !== exp_a[c-1])
          $display("FAIL %s addr_a cycle %0d: got %0d expected %0d", name, c, addr_a, exp_a[c-1]);
        if (addr_a !== exp_a[c-1]) errors++;
        checks++;
        if (addr_b !== exp_b[c-1]) begin
          $display("FAIL %s addr_b cycle %0d: got %0d expected %0d", name, c, addr_b, exp_b[c-1]);
          errors++;
        end
      end
      checks++;
      if (done !== (c == N + 2) || busy !== (c <= N + 2)) begin
        $display("FAIL %s done/busy cycle %0d: got %b/%b expected %b/%b", name, c, done, busy,
                 (c == N + 2), (c <= N + 2));
        errors++;
      end
      if (c == N + 2) begin
        checks++;
        if ({collision1, collision2} !== {exp_c1, exp_c2}) begin
          $display("FAIL %s collisions: got %b%b expected %b%b", name, collision1, collision2,
                   exp_c1, exp_c2);
          errors++;
        end
      end
    end
    set_ships(sv[0], sv[1], sv[2], sv[3]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    set_ships(10'd100, 10'd100, 10'd300, 10'd200);
    repeat (3) tick();
    checks++;
    if ({addr_a, addr_b, collision1, collision2, busy, done} !== 38'd0) begin
      $display("FAIL reset_state: got a=%0d b=%0d c1=%b c2=%b busy=%b done=%b expected all 0",
               addr_a, addr_b, collision1, collision2, busy, done);
      errors++;
    end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_free_map();
`ifdef COLLISION_SCAN_8PT_EN
    exp_a = '{17'd16050, 17'd16058, 17'd16066, 17'd19890, 17'd19906, 17'd23730, 17'd23738, 17'd23746};
    exp_b = '{17'd32150, 17'd32158, 17'd32166, 17'd35990, 17'd36006, 17'd39830, 17'd39838, 17'd39846};
`else
    exp_a = '{17'd16050, 17'd16066, 17'd23730, 17'd23746, 17'd0, 17'd0, 17'd0, 17'd0};
    exp_b = '{17'd32150, 17'd32166, 17'd39830, 17'd39846, 17'd0, 17'd0, 17'd0, 17'd0};
`endif
    run_scan("free_map", 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_wall_hit();
    logic exp1;
    exp1 = (N == 8);
    mem[19906] = 1'b0;
    run_scan("wall_hit", 0, 1'b1, exp1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (collision1 !== exp1 || collision2 !== 1'b0 || done !== 1'b0) begin
        $display("FAIL wall_hold idle %0d: got c1=%b c2=%b done=%b expected c1=%b c2=0 done=0",
                 i, collision1, collision2, done, exp1);
        errors++;
      end
    end
    mem[19906] = 1'b1;
  endtask

  task automatic test_out_of_bounds();
    set_ships(10'd100, 10'd100, 10'd620, 10'd200);
`ifdef COLLISION_SCAN_8PT_EN
    exp_b = '{17'd32310, 17'd32318, 17'd0, 17'd36150, 17'd0, 17'd39990, 17'd39998, 17'd0};
`else
    exp_b = '{17'd32310, 17'd0, 17'd39990, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0};
`endif
    run_scan("oob", 0, 1'b1, 1'b0, 1'b1);
    set_ships(10'd100, 10'd100, 10'd300, 10'd200);
  endtask

  task automatic test_start_ignored();
    int extra;
    extra = 0;
    test_free_map();
    exp_b = exp_b;
    run_scan("start_ignored", 4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      $display("FAIL start_ignored extra activity: got %0d cycles expected 0", extra);
      errors++;
    end
  endtask

  task automatic test_reset_mid_scan();
    int dcount;
    dcount = 0;
    mem[16050] = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({addr_a, addr_b, collision1, collision2, busy, done} !== 38'd0) begin
      $display("FAIL reset_mid outputs: got a=%0d b=%0d c1=%b c2=%b busy=%b done=%b expected all 0",
               addr_a, addr_b, collision1, collision2, busy, done);
      errors++;
    end
    tick();
    reset = 1'b0;
    mem[16050] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    checks++;
    if (dcount !== 0) begin
      $display("FAIL reset_mid no_done: got %0d active cycles expected 0", dcount);
      errors++;
    end
    test_free_map();
  endtask

  task automatic test_corner_wall();
    mem[16058] = 1'b0;
    run_scan("corner_wall", 0, 1'b0, (N == 8), 1'b0);
    mem[16058] = 1'b1;
  endtask

  task automatic test_back_to_back();
    int first_d, second_d, cnt;
    first_d = -1; second_d = -1; cnt = 0;
    start = 1'b1;
    for (int c = 1; c <= 2 * N + 8; c++) begin
      tick();
      if (c == 2 * N + 5) start = 1'b0;
      if (done === 1'b1) begin
        cnt++;
        if (first_d < 0) first_d = c;
        else if (second_d < 0) second_d = c;
      end
    end
    checks++;
    if (cnt !== 2 || first_d !== N + 2 || second_d !== 2 * N + 5) begin
      $display("FAIL back_to_back: got %0d dones at %0d,%0d expected 2 at %0d,%0d",
               cnt, first_d, second_d, N + 2, 2 * N + 5);
      errors++;
    end
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL back_to_back busy_after: got %b expected 0", busy);
      errors++;
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 1'b1;
    test_reset();
    test_free_map();
    test_wall_hit();
    test_out_of_bounds();
    test_start_ignored();
    test_reset_mid_scan();
    test_corner_wall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/collision_scan_ctrl.md
# collision_scan_ctrl

Sequencer that shares the dual-port collision map between both ships and scans a multi-point hitbox per frame instead of a single pixel. On each `start` pulse (one per frame, from vsync) it latches both ship positions and walks a fixed list of perimeter probe points, driving port A for ship 1 and port B for ship 2 in parallel. It accumulates hits and publishes registered `collision1`/`collision2` flags plus a `done` pulse to the game logic. It sits between the ship position registers and the `collision_map` RAM and replaces direct address generation.

## Interface
- `SHIP_W`, 32: hitbox width in screen pixels; must be even.
- `SHIP_H`, 48: hitbox height in screen pixels; must be even.
- `MAP_W`, 320: collision map row stride, in half-resolution cells.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: frame scan request; honoured only in IDLE.
- `x_pos1`, `y_pos1`, `x_pos2`, `y_pos2` in 10 each: ship top-left corner in 640x480 screen coordinates.
- `addr_a`, `addr_b` out 17 each: collision map addresses for ship 1 and ship 2.
- `q_a`, `q_b` in 1 each: map data; 0 = wall, 1 = free. Valid one clock after the address.
- `collision1`, `collision2` out 1 each: result of the last completed scan.
- `busy` out 1: high from the cycle after `start` is accepted through DONE.
- `done` out 1: one-cycle pulse when results update.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- Reset: state = IDLE; `addr_a`/`addr_b`, `collision1`/`collision2`, `busy`, `done`, and the hit accumulators are all 0.
- IDLE → SCAN on `start`:
  - latch all four positions;
  - clear accumulators `hit1`/`hit2`;
  - probe index p = 0.
- `start` is ignored in SCAN, DRAIN and DONE. Latched positions are used for the entire scan.
- SCAN issues probe p on both ports each cycle, then increments p. After the last probe (p = N−1) it moves to DRAIN.
- Probe offsets (dx, dy), in order, with N = 8:
  - (0,0), (W/2,0), (W,0);
  - (0,H/2), (W,H/2);
  - (0,H), (W/2,H), (W,H).
- Address arithmetic:
  - px = x + dx and py = y + dy, computed 11 bits wide;
  - addr = (px >> 1) + (py >> 1) * MAP_W, truncated to 17 bits.
- Out of bounds: a probe with px > 639 or py > 479 is out of bounds and counts as a hit. Its address output is forced to 0, and an `oob` flag is registered alongside the address.
- Hit update: in the cycle after a probe is issued, `hit_n |= oob_d | ~q`. This applies in the cycles following each SCAN probe and in DRAIN.
- DRAIN: samples the last probe's data, then goes to DONE.
- DONE:
  - `collision1 <= hit1` and `collision2 <= hit2`;
  - `done` = 1 for this cycle;
  - next state is IDLE.
- Addresses are 0 in IDLE, DRAIN and DONE.
- `collision1`/`collision2` hold their value between scans.

## Timing
- Cycle 0: `start` = 1 sampled in IDLE.
- Cycles 1..N: SCAN, with probe p on `addr_a`/`addr_b` in cycle 1+p.
- Cycle N+1: DRAIN.
- Cycle N+2: DONE. `done` = 1 and the new collision values are visible this cycle.
- Cycle N+3: IDLE; a new `start` may be accepted here.
- Latency from `start` to `done`: 10 cycles with N = 8, 6 cycles with N = 4. No back-to-back overlap.
- `start` held high: a new scan is accepted on each return to IDLE.
- Reset asserted mid-scan: immediate return to IDLE, all outputs 0, and no `done` pulse. The partial scan is discarded.
- Both ports operate independently. Identical addresses on A and B are legal because the RAM is read-only.

## Configuration
- `COLLISION_SCAN_8PT_EN` defined: N = 8, using the perimeter list above.
- `COLLISION_SCAN_8PT_EN` undefined: N = 4, corners only, in the order (0,0), (W,0), (0,H), (W,H).
  - Latency becomes 6 cycles.
  - All other behaviour is identical.

## Test plan
- All-free map, ship1 at (100,100), ship2 at (300,200), `start` pulse:
  - addr_a sequence is 16050, 16058, 16066, 19890, 19906, 23730, 23738, 23746;
  - `done` comes 10 cycles after `start`, with collision1 = collision2 = 0.
- Single wall cell at address 19906 (the (W,H/2) probe of ship1): collision1 = 1, collision2 = 0, and the values hold through 20 idle cycles.
- Ship2 at x = 620 on a free map: probes with px ≥ 640 are out of bounds, so collision2 = 1 and addr_b = 0 on those probe cycles.
- Second `start` pulse asserted in cycle 4 of a scan: it is ignored; exactly one `done` occurs, at cycle 10.
- `reset` asserted in cycle 5 of a scan with a wall hit pending: outputs go to 0 immediately, no `done`, and the next `start` runs a clean scan.
- Build without `COLLISION_SCAN_8PT_EN`, with a wall only at ship1's (W/2,0) probe: collision1 = 0 and `done` arrives 6 cycles after `start`.
